// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with registered single-cycle ops and iterative restoring divider
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [SHW-1:0]   r_cnt;
    logic             r_is_rem;

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_dbz;
    logic             w_zero_en;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_sh;
    logic             w_is_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_div_res;
    logic             w_div_last;

    assign in_ready = (r_state == S_IDLE);

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_dbz     = 1'b0;
        w_zero_en = 1'b1;
        w_sum     = {1'b0, a} + {1'b0, b};
        w_sh      = b[SHW-1:0];
        case (alu_sel)
            4'b0000: begin w_res = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH]; end
            4'b0001: begin w_res = a - b; w_carry = (a < b); end
            4'b0010: w_res = a * b;
            4'b0011: begin w_res = '1; w_dbz = 1'b1; end
            4'b0100: w_res = a & b;
            4'b0101: w_res = a | b;
            4'b0110: w_res = ~(a | b);
            4'b0111: w_res = a << w_sh;
            4'b1000: w_res = a >> w_sh;
            4'b1001: w_res = WIDTH'($signed(a) >>> w_sh);
            4'b1010: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1011: w_res = {{(WIDTH-1){1'b0}}, a < b};
            4'b1100: begin w_res = a; w_dbz = 1'b1; end
            default: begin w_res = '0; w_zero_en = 1'b0; end
        endcase
    end

    // Divide-by-zero divu/remu never enter the iterative path; w_dbz only reaches the output then.
    assign w_is_div = (alu_sel == 4'b0011) || (alu_sel == 4'b1100);

    // r_quo starts as the dividend: its MSB feeds the remainder while quotient bits shift in at the LSB.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
    assign w_div_res  = r_is_rem ? w_rem_next : w_quo_next;
    assign w_div_last = (r_cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_quo       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_is_rem    <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_div && (b != '0)) begin
                            r_quo     <= a;
                            r_rem     <= '0;
                            r_divisor <= b;
                            r_cnt     <= '0;
                            r_is_rem  <= (alu_sel == 4'b1100);
                            r_state   <= S_DIV;
                        end else begin
                            result      <= w_res;
                            zero        <= w_zero_en && (w_res == '0);
                            carry       <= w_carry;
                            div_by_zero <= w_dbz;
                            out_valid   <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_div_last) begin
                        result      <= w_div_res;
                        zero        <= (w_div_res == '0);
                        carry       <= 1'b0;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with randomized ops and reference model
module tb_alu_multicycle;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         d;
        longint       cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_sel = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         div_by_zero;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    exp_t   sb[$];
    logic   started = 1'b0;
    logic   stall_next = 1'b0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .a(op_a), .b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table, using wide arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t            e;
        logic [W:0]      s;
        logic [W-1:0]    ones;
        longint unsigned p;
        int              sh;
        e.res = '0; e.z = 1'b0; e.c = 1'b0; e.d = 1'b0; e.cyc = 0;
        ones = '1;
        sh = int'(y % W);
        case (op)
            4'd0:  begin s = x + y; e.res = s[W-1:0]; e.c = s[W]; end
            4'd1:  begin e.res = x - y; e.c = (x < y); end
            4'd2:  begin p = 64'(x) * 64'(y); e.res = p[W-1:0]; end
            4'd3:  begin e.res = (y == 0) ? ones : x / y; e.d = (y == 0); end
            4'd4:  e.res = x & y;
            4'd5:  e.res = x | y;
            4'd6:  e.res = ~(x | y);
            4'd7:  e.res = x << sh;
            4'd8:  e.res = x >> sh;
            4'd9:  e.res = (x >> sh) | (x[W-1] ? ~(ones >> sh) : '0);
            4'd10: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'd11: e.res = (x < y) ? W'(1) : W'(0);
            4'd12: begin e.res = (y == 0) ? x : x % y; e.d = (y == 0); end
            default: e.res = '0;
        endcase
        e.z = (op <= 4'd12) && (e.res == '0);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   waitc = 0;
        in_valid = 1'b1; alu_sel = op; op_a = x; op_b = y;
        while (!in_ready) begin
            @(negedge clk);
            waitc++;
            if (waitc > 200) begin
                $display("FAIL in_ready_timeout actual=0 expected=1");
                $fatal(1, "in_ready never returned");
            end
        end
        e = model(op, x, y);
        e.cyc = cyc + 1 + (((op == 4'd3 || op == 4'd12) && y != 0) ? W : 0);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waitc = 0;
        while (sb.size() != 0 || out_valid) begin
            @(negedge clk);
            waitc++;
            if (waitc > 300) begin
                $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
                $fatal(1, "scoreboard did not drain");
            end
        end
    endtask

    exp_t         cur;
    logic         held = 1'b0;
    logic         expect_drop = 1'b0;
    int           hold = 0;
    logic [W-1:0] snap_res;
    logic [2:0]   snap_flags;

    always @(negedge clk) begin
        if (rst || !started) begin
            held = 1'b0; expect_drop = 1'b0; out_ready = 1'b0;
        end else if (expect_drop) begin
            check("valid_drop", out_valid, 0);
            expect_drop = 1'b0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            check("no_accept_while_valid", in_ready, 0);
            if (!held) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check("latency", cyc, cur.cyc);
                    check("result", result, cur.res);
                    check("flags_zcd", {zero, carry, div_by_zero}, {cur.z, cur.c, cur.d});
                end
                snap_res = result;
                snap_flags = {zero, carry, div_by_zero};
                held = 1'b1;
                hold = stall_next ? 5 : int'($urandom_range(0, 2));
            end else begin
                check("hold_result", result, snap_res);
                check("hold_flags", {zero, carry, div_by_zero}, snap_flags);
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = 1'b1;
                held = 1'b0;
                expect_drop = 1'b1;
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] x, y;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_flags", {zero, carry, div_by_zero}, 0);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);

        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        issue(4'd1, 32'd3, 32'd5);
        issue(4'd9, 32'h8000_0000, 32'h24);
        issue(4'd3, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("in_ready_mid_div", in_ready, 0);
        issue(4'd12, 32'd100, 32'd7);
        issue(4'd3, 32'd5, 32'd0);
        issue(4'd12, 32'd5, 32'd0);
        issue(4'd13, 32'd1, 32'd1);
        wait_drain();

        stall_next = 1'b1;
        issue(4'd1, 32'd10, 32'd3);
        @(negedge clk);
        stall_next = 1'b0;
        issue(4'd5, 32'h00F0, 32'h0F00);
        wait_drain();

        issue(4'd3, 32'hDEAD_BEEF, 32'd13);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        check("midrst_flags", {zero, carry, div_by_zero}, 0);
        issue(4'd0, 32'd20, 32'd22);
        wait_drain();

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 40));
                default: y = $urandom;
            endcase
            issue(op, x, y);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
